// File: rtl/fm_tx_controller.sv
// FM transmitter configuration/sequencing controller: byte-serial command port,
// shadow->active commit on audio tick, prescaler and audio pacing. Optional FM_SWEEP_EN.
`timescale 1ns/1ps
module fm_tx_controller #(
  parameter int             A       = 8,
  parameter int             N       = 18,
  parameter int             CW      = 2,
  parameter int             FW      = 4,
  parameter logic [15:0]    PRE_RST = 16'd63,
  parameter logic [N-1:0]   INC_RST = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    cfg_data,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [A-1:0]  audio_in,
  input  logic          audio_valid,
  output logic [N-1:0]  acc_inc,
  output logic [CW-1:0] df_coef,
  output logic [FW-1:0] df_fact,
  output logic [A-1:0]  audio_out,
  output logic          sample_tick,
  output logic          tx_en,
  output logic          cfg_err
);

  typedef enum logic [1:0] {IDLE, DATA, COMMIT_WAIT} state_t;

  localparam logic [3:0] OP_INC    = 4'h1;
  localparam logic [3:0] OP_DF     = 4'h2;
  localparam logic [3:0] OP_PRE    = 4'h3;
  localparam logic [3:0] OP_COMMIT = 4'h4;
  localparam logic [3:0] OP_TXON   = 4'h5;
  localparam logic [3:0] OP_TXOFF  = 4'h6;
  localparam logic [3:0] OP_STEP   = 4'h7;

  state_t        state, state_nxt;
  logic [3:0]    op_q;
  logic [1:0]    bcnt;
  logic [3:0]    hdr_op;
  logic [1:0]    hdr_len;
  logic          hdr_known;
  logic          xfer, hdr, commit;

  logic [N-1:0]  inc_sh, inc_act;
  logic [15:0]   pre_sh, pre_act, pcnt;
  logic [CW-1:0] coef_sh, coef_act;
  logic [FW-1:0] fact_sh, fact_act;
  logic [A-1:0]  pend;
  logic [N+7:0]  inc_shift;
  logic [3:0]    df_hi;
`ifdef FM_SWEEP_EN
  logic [15:0]   step;
`endif

  assign cfg_ready   = (state != COMMIT_WAIT);
  assign xfer        = cfg_valid && cfg_ready;
  assign hdr         = xfer && (state == IDLE);
  assign hdr_op      = cfg_data[7:4];
  assign sample_tick = (pcnt == pre_act);
  assign commit      = (state == COMMIT_WAIT) && sample_tick;
  assign inc_shift   = {inc_sh, cfg_data};
  assign df_hi       = cfg_data[7:4];

  assign acc_inc = tx_en ? inc_act : '0;
  assign df_coef = coef_act;
  assign df_fact = fact_act;

  // Header decode: number of trailing data bytes and opcode validity.
  always_comb begin
    hdr_len   = 2'd0;
    hdr_known = 1'b1;
    case (hdr_op)
      OP_INC:    hdr_len = 2'd3;
      OP_DF:     hdr_len = 2'd1;
      OP_PRE:    hdr_len = 2'd2;
      OP_COMMIT, OP_TXON, OP_TXOFF: hdr_len = 2'd0;
`ifdef FM_SWEEP_EN
      OP_STEP:   hdr_len = 2'd2;
`endif
      default:   hdr_known = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (hdr && hdr_known) begin
          if (hdr_op == OP_COMMIT)  state_nxt = COMMIT_WAIT;
          else if (hdr_len != 2'd0) state_nxt = DATA;
        end
      end
      DATA:        if (xfer && bcnt == 2'd1) state_nxt = IDLE;
      COMMIT_WAIT: if (sample_tick)          state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  // Command register file: shadow loads, header side effects, byte counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= '0;
      bcnt    <= '0;
      tx_en   <= 1'b0;
      cfg_err <= 1'b0;
      inc_sh  <= INC_RST;
      pre_sh  <= PRE_RST;
      coef_sh <= '0;
      fact_sh <= '0;
`ifdef FM_SWEEP_EN
      step    <= '0;
`endif
    end else if (hdr) begin
      op_q    <= hdr_op;
      bcnt    <= hdr_len;
      cfg_err <= !hdr_known;
      if (hdr_op == OP_TXON)  tx_en <= 1'b1;
      if (hdr_op == OP_TXOFF) tx_en <= 1'b0;
    end else if (xfer && state == DATA) begin
      bcnt <= bcnt - 2'd1;
      case (op_q)
        OP_INC: inc_sh <= inc_shift[N-1:0];
        OP_DF: begin
          fact_sh <= FW'(df_hi);
          coef_sh <= cfg_data[CW-1:0];
        end
        OP_PRE:  pre_sh <= {pre_sh[7:0], cfg_data};
`ifdef FM_SWEEP_EN
        OP_STEP: step   <= {step[7:0], cfg_data};
`endif
        default: ;
      endcase
    end
  end

  // Tick-aligned datapath: prescaler, commit of active settings, audio pacing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt      <= '0;
      pre_act   <= PRE_RST;
      inc_act   <= INC_RST;
      coef_act  <= '0;
      fact_act  <= '0;
      pend      <= '0;
      audio_out <= '0;
    end else begin
      if (audio_valid) pend <= audio_in;
      if (sample_tick) begin
        pcnt      <= '0;
        audio_out <= tx_en ? pend : '0;
      end else begin
        pcnt <= pcnt + 16'd1;
      end
      if (commit) begin
        pre_act  <= pre_sh;
        inc_act  <= inc_sh;
        coef_act <= coef_sh;
        fact_act <= fact_sh;
      end
`ifdef FM_SWEEP_EN
      else if (sample_tick && step != 16'd0) begin
        inc_act <= inc_act + N'(step);
      end
`endif
    end
  end

endmodule

// File: tb/tb_fm_tx_controller.sv
// Directed self-checking bench for fm_tx_controller (default parameters).
`timescale 1ns/1ps
module tb_fm_tx_controller;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cfg_data;
  logic        cfg_valid;
  logic        cfg_ready;
  logic [7:0]  audio_in;
  logic        audio_valid;
  logic [17:0] acc_inc;
  logic [1:0]  df_coef;
  logic [3:0]  df_fact;
  logic [7:0]  audio_out;
  logic        sample_tick;
  logic        tx_en;
  logic        cfg_err;

  int vec = 0;
  int err = 0;

  fm_tx_controller dut (
    .clk(clk), .rst_n(rst_n), .cfg_data(cfg_data), .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready), .audio_in(audio_in), .audio_valid(audio_valid),
    .acc_inc(acc_inc), .df_coef(df_coef), .df_fact(df_fact), .audio_out(audio_out),
    .sample_tick(sample_tick), .tx_en(tx_en), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    cfg_data = b; cfg_valid = 1'b1;
    while (!cfg_ready && n < 300) begin @(negedge clk); n++; end
    if (!cfg_ready) begin
      err++; $display("FAIL send_timeout byte=%h ready=%b want 1", b, cfg_ready);
    end
    @(posedge clk); #1;
    cfg_valid = 1'b0;
  endtask

  task automatic wait_tick();
    int n = 0;
    @(negedge clk);
    while (!sample_tick && n < 300) begin @(negedge clk); n++; end
    if (!sample_tick) begin
      err++; $display("FAIL tick_timeout got sample_tick=%b want 1", sample_tick);
    end
  endtask

  task automatic test_reset();
    int ticks[$];
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0; audio_valid = 1'b0; audio_in = '0;
    repeat (3) @(negedge clk);
    vec++; if ({cfg_ready, sample_tick, tx_en, cfg_err} !== 4'b1000) begin
      err++; $display("FAIL reset_flags got %b want 1000", {cfg_ready, sample_tick, tx_en, cfg_err}); end
    vec++; if ({acc_inc, df_coef, df_fact, audio_out} !== '0) begin
      err++; $display("FAIL reset_data got %h/%h/%h/%h want 0", acc_inc, df_coef, df_fact, audio_out); end
    rst_n = 1'b1;
    for (int k = 1; k <= 192; k++) begin
      @(negedge clk);
      if (sample_tick) ticks.push_back(k);
    end
    vec++; if (ticks.size() !== 3) begin
      err++; $display("FAIL reset_tick_count got %0d want 3", ticks.size()); end
    else begin
      vec++; if (ticks[0] !== 63 || ticks[1] !== 127 || ticks[2] !== 191) begin
        err++; $display("FAIL reset_tick_cycles got %0d,%0d,%0d want 63,127,191", ticks[0], ticks[1], ticks[2]); end
    end
  endtask

  task automatic test_commit();
    send(8'h50);
    send(8'h10); send(8'h01); send(8'h23); send(8'h45);
    send(8'h20); send(8'hA7);
    send(8'h40);
    vec++; if (cfg_ready !== 1'b0 || acc_inc !== 18'h0) begin
      err++; $display("FAIL commit_wait got ready=%b acc=%h want 0/0", cfg_ready, acc_inc); end
    wait_tick();
    vec++; if (cfg_ready !== 1'b0 || acc_inc !== 18'h0 || df_fact !== 4'h0) begin
      err++; $display("FAIL commit_pre got ready=%b acc=%h fact=%h want 0/0/0", cfg_ready, acc_inc, df_fact); end
    @(negedge clk);
    vec++; if (acc_inc !== 18'h12345 || cfg_ready !== 1'b1) begin
      err++; $display("FAIL commit_inc got acc=%h ready=%b want 12345/1", acc_inc, cfg_ready); end
    vec++; if (df_fact !== 4'hA || df_coef !== 2'h3) begin
      err++; $display("FAIL commit_df got fact=%h coef=%h want a/3", df_fact, df_coef); end
    send(8'h50);
  endtask

  task automatic test_prescaler();
    int gap;
    send(8'h30); send(8'h00);
    repeat (5) @(negedge clk);
    vec++; if (cfg_ready !== 1'b1 || acc_inc !== 18'h12345) begin
      err++; $display("FAIL pre_stall got ready=%b acc=%h want 1/12345", cfg_ready, acc_inc); end
    send(8'h03); send(8'h40);
    wait_tick();
    for (int r = 0; r < 2; r++) begin
      gap = 0;
      do begin @(negedge clk); gap++; end while (!sample_tick && gap < 100);
      vec++; if (gap !== 4) begin
        err++; $display("FAIL pre_period%0d got %0d want 4", r, gap); end
    end
  endtask

  task automatic test_audio();
    wait_tick();
    @(negedge clk); audio_valid = 1'b1; audio_in = 8'h12;
    @(negedge clk); audio_in = 8'h7F;
    @(negedge clk); audio_valid = 1'b0;
    wait_tick();
    @(negedge clk);
    vec++; if (audio_out !== 8'h7F) begin
      err++; $display("FAIL audio_last_wins got %h want 7f", audio_out); end
    wait_tick();
    audio_valid = 1'b1; audio_in = 8'h80;
    @(negedge clk); audio_valid = 1'b0;
    vec++; if (audio_out !== 8'h7F) begin
      err++; $display("FAIL audio_same_tick got %h want 7f", audio_out); end
    wait_tick();
    @(negedge clk);
    vec++; if (audio_out !== 8'h80) begin
      err++; $display("FAIL audio_next_tick got %h want 80", audio_out); end
    send(8'h60);
    vec++; if (acc_inc !== 18'h0 || tx_en !== 1'b0 || audio_out !== 8'h80) begin
      err++; $display("FAIL txoff_gate got acc=%h en=%b aud=%h want 0/0/80", acc_inc, tx_en, audio_out); end
    wait_tick();
    @(negedge clk);
    vec++; if (audio_out !== 8'h00) begin
      err++; $display("FAIL txoff_audio got %h want 00", audio_out); end
  endtask

  task automatic test_err();
    send(8'hF0);
    vec++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      err++; $display("FAIL err_set got err=%b ready=%b want 1/1", cfg_err, cfg_ready); end
    send(8'h50);
    vec++; if (tx_en !== 1'b1 || cfg_err !== 1'b0) begin
      err++; $display("FAIL err_idle got en=%b err=%b want 1/0", tx_en, cfg_err); end
    send(8'hF0);
    send(8'h60);
    vec++; if (cfg_err !== 1'b0 || tx_en !== 1'b0) begin
      err++; $display("FAIL err_clear got err=%b en=%b want 0/0", cfg_err, tx_en); end
  endtask

  task automatic test_sweep();
`ifdef FM_SWEEP_EN
    send(8'h10); send(8'h03); send(8'hFF); send(8'hFF); send(8'h40);
    wait_tick();
    send(8'h50);
    vec++; if (acc_inc !== 18'h3FFFF) begin
      err++; $display("FAIL sweep_base got %h want 3ffff", acc_inc); end
    send(8'h70); send(8'h00); send(8'h02);
    vec++; if (cfg_err !== 1'b0) begin
      err++; $display("FAIL sweep_op got err=%b want 0", cfg_err); end
    wait_tick();
    @(negedge clk);
    vec++; if (acc_inc !== 18'h00001) begin
      err++; $display("FAIL sweep_wrap got %h want 00001", acc_inc); end
    send(8'h70); send(8'h00); send(8'h00);
`else
    send(8'h70);
    vec++; if (cfg_err !== 1'b1 || cfg_ready !== 1'b1) begin
      err++; $display("FAIL step_unknown got err=%b ready=%b want 1/1", cfg_err, cfg_ready); end
    send(8'h60);
`endif
  endtask

  task automatic test_reset_mid();
    send(8'h10); send(8'h01); send(8'h23);
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    vec++; if (cfg_ready !== 1'b1 || acc_inc !== 18'h0 || tx_en !== 1'b0) begin
      err++; $display("FAIL rstmid_state got ready=%b acc=%h en=%b want 1/0/0", cfg_ready, acc_inc, tx_en); end
    rst_n = 1'b1;
    send(8'h40);
    wait_tick();
    @(negedge clk);
    send(8'h50);
    vec++; if (acc_inc !== 18'h0 || tx_en !== 1'b1 || cfg_ready !== 1'b1) begin
      err++; $display("FAIL rstmid_inc got acc=%h en=%b ready=%b want 0/1/1", acc_inc, tx_en, cfg_ready); end
  endtask

  initial begin
    test_reset();
    test_commit();
    test_prescaler();
    test_audio();
    test_err();
    test_sweep();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog");
  end
endmodule
